// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the 5-input truth-table scanner.
package truth_table_pkg;

  localparam int N_IN   = 5;
  localparam int N_IDX  = 32;
  localparam int ONES_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_scanner.sv
// Walks all 32 input patterns of a 5-input function, waits SETTLE cycles per
// pattern, then captures F into a truth table and counts the minterms.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start, A-E held at 0
// ST_SETTLE | pattern idx driven, counting down the settle window
// ST_SAMPLE | one cycle; closing edge captures F into tbl[idx]
// ST_DONE   | one-cycle done pulse, results frozen
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              F,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  output logic              E,
  output logic              busy,
  output logic              done,
  output logic [N_IDX-1:0]  tbl,
  output logic [ONES_W-1:0] ones
);

  localparam logic             BYPASS    = (SETTLE == 0);
  localparam int unsigned      SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0]       CNT_LOAD  = 4'(SETTLE_M1);
  localparam logic [N_IN-1:0]  IDX_LAST  = N_IN'(N_IDX - 1);

  state_t             state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [N_IDX-1:0]   tbl_q, tbl_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tbl_q   <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = BYPASS ? ST_SAMPLE : ST_SETTLE;
      ST_SETTLE: if (cnt_q == 4'd0) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        if (idx_q == IDX_LAST) state_d = ST_DONE;
        else                   state_d = BYPASS ? ST_SAMPLE : ST_SETTLE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Index, settle timer and result accumulation.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    tbl_d  = tbl_q;
    ones_d = ones_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d  = '0;
          cnt_d  = CNT_LOAD;
          tbl_d  = '0;
          ones_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      ST_SAMPLE: begin
        tbl_d[idx_q] = F;
        ones_d       = ones_q + ONES_W'(F);
        if (idx_q != IDX_LAST) begin
          idx_d = idx_q + N_IN'(1);
          cnt_d = CNT_LOAD;
        end
      end
      ST_DONE: idx_d = '0;
      default: idx_d = '0;
    endcase
  end

  always_comb begin
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  // idx_q is itself a flop, so A-E are registered and only change on index steps.
  assign {A, B, C, D, E} = idx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tbl  = tbl_q;
  assign ones = ones_q;

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving the wait cycles between driving an input pattern and sampling F; legal range 0..15.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  scan request, sampled only in IDLE.
REQ-005 SHALL have port F  input  1  output of the 5-input combinational function under test.
REQ-006 SHALL have ports A, B, C, D, E  output  1 each  stimulus to the function under test; {A,B,C,D,E} = current index, A is the MSB.
REQ-007 SHALL have port busy  output  1  high while a scan is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a scan completes.
REQ-009 SHALL have port table  output  32  captured truth table; bit i = F observed at index i.
REQ-010 SHALL have port ones  output  6  count of minterms (1s in table), range 0..32.

Function
REQ-011 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-012 IDLE with start=1 at a clock edge SHALL go to SETTLE, set idx=0, clear table and ones, and set busy=1.
REQ-013 SETTLE SHALL hold for exactly SETTLE cycles, using a 4-bit counter, then go to SAMPLE; SETTLE=0 SHALL bypass SETTLE and go straight to SAMPLE.
REQ-014 SAMPLE SHALL last 1 cycle; on its closing edge it SHALL write table[idx]=F and add F to ones.
REQ-015 After SAMPLE with idx<31, the FSM SHALL increment idx and return to SETTLE (or to SAMPLE if SETTLE=0).
REQ-016 After SAMPLE with idx=31, the FSM SHALL go to DONE without wrapping idx.
REQ-017 DONE SHALL last 1 cycle with done=1 and busy=0, then go to IDLE.
REQ-018 A–E SHALL be registered outputs equal to idx, stable for the entire SETTLE+SAMPLE window of each index.
REQ-019 Latency: done SHALL be high in the cycle 32*(SETTLE+1)+1 cycles after the start-accepting edge (65 cycles for SETTLE=1).
REQ-020 start SHALL be ignored in SETTLE, SAMPLE and DONE; start held high through DONE SHALL launch a new scan on the first IDLE cycle.
REQ-021 table and ones SHALL stay stable from DONE until the next accepted start, and SHALL be meaningful only when busy=0.
REQ-022 In IDLE, A–E SHALL return to 0.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=IDLE, idx=0, settle counter=0, A–E=0, busy=0, done=0, table=0, ones=0.
REQ-024 rst SHALL take priority over start and over any state, including mid-scan; no partial table SHALL survive reset.

Structure
REQ-025 Package truth_table_pkg SHALL hold the state enum, N_IN=5, N_IDX=32 and the ones width (6).
REQ-026 No sub-module is needed: a single module containing the FSM, index counter, settle counter, table shift/write and ones accumulator, 120–250 lines of RTL.

Verification
REQ-027 F tied 0, SETTLE=1: start -> done at cycle 65, table=32'h00000000, ones=0.
REQ-028 F tied 1: start -> table=32'hFFFFFFFF, ones=32 (max-count boundary).
REQ-029 F=E (combinational from DUT outputs): table=32'hAAAAAAAA, ones=16; F=A&B: table=32'hFF000000, ones=8.
REQ-030 SETTLE=0 with F=A&B: done 33 cycles after start, same table; SETTLE=3: done at cycle 129.
REQ-031 rst asserted while idx=10 -> next cycle busy=0, table=0, ones=0, A–E=0; a following start gives a full correct scan.
REQ-032 start pulsed at idx=5 and held high through DONE -> the running scan is unaffected, and a second scan begins on the first IDLE cycle with table cleared.
